turn_ctrl: RTL and testbench
============================

# turn_ctrl

Turn sequencer for the two-board cat-and-dog throwing game. It owns the inter-board link: the ready, throw flag and 5-bit power lines exchanged between the two boards. It synchronises the incoming link signals and decides which side may throw. It sequences each throw through a fixed-length flight window, then hands the turn to the other board. It sits between the local input logic (player select, mouse-driven power/throw) and the game drawing logic.

## Interface
- POWER_W, 5, width of throw power on the link
- SYNC_STAGES, 2, flip-flop stages on each incoming link bit
- THROW_FRAMES, 120, flight duration in frame_tick pulses (≥1)

- clk  in  1  single system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- local_is_p1  in  1  this board is player 1 (moves first); sampled only in IDLE
- local_ready  in  1  level, local player has chosen a character
- local_throw  in  1  one-cycle pulse, throw request
- local_power  in  POWER_W  power accompanying local_throw
- frame_tick  in  1  one-cycle pulse per video frame
- game_over  in  1  one-cycle pulse, abort to IDLE
- in_ready, in_throw_flag  in  1  remote link bits, asynchronous
- in_power  in  POWER_W  remote power, asynchronous
- out_ready, out_throw_flag  out  1  link bits to remote board
- out_power  out  POWER_W  power to remote board
- my_turn  out  1  high in LOCAL_TURN
- throw_active  out  1  high in LOCAL_FLIGHT or REMOTE_FLIGHT
- throw_local  out  1  high in LOCAL_FLIGHT
- throw_power  out  POWER_W  power of the current or last throw
- anim_start  out  1  one-cycle pulse when a flight begins

## Operation
- Each in_* bit passes through its own SYNC_STAGES synchroniser: rin_ready, rin_flag, rin_power. rin_flag has a registered rising-edge detector.
- ready_latch: set by local_ready while in IDLE; cleared by game_over, by reset, or by any return to IDLE. out_ready = ready_latch.
- States: IDLE, LOCAL_TURN, LOCAL_ARM, LOCAL_FLIGHT, REMOTE_TURN, REMOTE_FLIGHT.
- IDLE:
  - When ready_latch & rin_ready, go to LOCAL_TURN if local_is_p1, else REMOTE_TURN.
- LOCAL_TURN:
  - When local_throw and local_power ≠ 0: load out_power and throw_power from local_power, then go to LOCAL_ARM.
  - A throw with power 0 is ignored.
- LOCAL_ARM:
  - Lasts one cycle.
  - Set out_throw_flag, pulse anim_start, clear the frame counter, go to LOCAL_FLIGHT.
- LOCAL_FLIGHT:
  - out_throw_flag held high; the counter increments on frame_tick.
  - On the tick that makes the count equal THROW_FRAMES: clear out_throw_flag, go to REMOTE_TURN.
- REMOTE_TURN:
  - On the rin_flag rising edge: throw_power ← rin_power, pulse anim_start, clear the counter, go to REMOTE_FLIGHT.
- REMOTE_FLIGHT:
  - Counts THROW_FRAMES ticks identically to LOCAL_FLIGHT, then goes to LOCAL_TURN.
  - The level of rin_flag is ignored here.
- local_throw outside LOCAL_TURN is dropped and not queued.
- Peer loss: rin_ready low in any non-IDLE state forces IDLE next cycle. In that cycle out_throw_flag, the counter and ready_latch clear; throw_power is kept.
- game_over in any state forces IDLE with the same clearing. It has priority over every other transition in the same cycle.
- out_power is held between throws, so it stays stable while out_throw_flag is high.
- Counter width is $clog2(THROW_FRAMES+1) and never wraps. frame_tick outside flight states is ignored.

## Timing
- Reset values: state IDLE; all outputs 0; counter 0; synchronisers and edge detector 0.
- Local throw accepted at cycle T:
  - T+1: out_power/throw_power valid, state LOCAL_ARM.
  - T+2: out_throw_flag=1, anim_start=1 (one cycle).
  - Power therefore leads the flag by one cycle, which guarantees the receiver captures settled power.
- Remote: in_throw_flag rising reaches rin_flag after SYNC_STAGES edges (cycle R). At R+1: state REMOTE_FLIGHT, throw_power valid, anim_start=1.
- Flight end: the state changes on the cycle after the THROW_FRAMES-th frame_tick is sampled.
- IDLE exit: the cycle after ready_latch and rin_ready are both high.
- Simultaneous local_throw and game_over: game_over wins; no throw.

## Test plan
- Start-up: reset; local_is_p1=1, local_ready=1, in_ready=1 → out_ready=1 next cycle; IDLE→LOCAL_TURN within SYNC_STAGES+2 cycles; my_turn=1.
- Local throw: power 17 → out_power=17 at T+1; out_throw_flag and anim_start at T+2; flag high for exactly THROW_FRAMES=3 ticks (bench override); then REMOTE_TURN.
- Remote throw: in_power=9, then in_throw_flag raised → throw_power=9 and anim_start one cycle wide at R+1; after 3 ticks → LOCAL_TURN.
- Ignored inputs: local_throw with power 0 in LOCAL_TURN, and power 5 in REMOTE_TURN → no state change, out_power unchanged.
- Abort: drop in_ready mid LOCAL_FLIGHT → IDLE, out_throw_flag=0, out_ready=0; separately, game_over coincident with local_throw → IDLE, no anim_start.
- Async reset asserted mid REMOTE_FLIGHT → all outputs 0 immediately without a clock edge.

Source files
------------

// File: rtl/turn_ctrl.sv
// Turn sequencer for the two-board throwing game: owns the ready/flag/power link,
// synchronises the remote side and walks each throw through a fixed flight window.
module turn_ctrl #(
  parameter int POWER_W      = 5,
  parameter int SYNC_STAGES  = 2,
  parameter int THROW_FRAMES = 120
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               local_is_p1,
  input  logic               local_ready,
  input  logic               local_throw,
  input  logic [POWER_W-1:0] local_power,
  input  logic               frame_tick,
  input  logic               game_over,
  input  logic               in_ready,
  input  logic               in_throw_flag,
  input  logic [POWER_W-1:0] in_power,
  output logic               out_ready,
  output logic               out_throw_flag,
  output logic [POWER_W-1:0] out_power,
  output logic               my_turn,
  output logic               throw_active,
  output logic               throw_local,
  output logic [POWER_W-1:0] throw_power,
  output logic               anim_start
);

  localparam int CNT_W  = $clog2(THROW_FRAMES + 1);
  localparam int LINK_W = POWER_W + 2;

  typedef enum logic [2:0] {
    IDLE, LOCAL_TURN, LOCAL_ARM, LOCAL_FLIGHT, REMOTE_TURN, REMOTE_FLIGHT
  } state_t;

  state_t             state_q, state_d;
  logic [LINK_W-1:0]  sync_q [SYNC_STAGES];
  logic               flag_prev_q;
  logic               ready_q, ready_d;
  logic               flag_q, flag_d;
  logic               anim_q, anim_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [POWER_W-1:0] opow_q, opow_d;
  logic [POWER_W-1:0] tpow_q, tpow_d;

  logic               rin_ready, rin_flag, rin_rise, last_tick;
  logic [POWER_W-1:0] rin_power;

  // Each link bit gets its own flop chain; the bundle is only a packing convenience.
  assign rin_ready = sync_q[SYNC_STAGES-1][LINK_W-1];
  assign rin_flag  = sync_q[SYNC_STAGES-1][POWER_W];
  assign rin_power = sync_q[SYNC_STAGES-1][POWER_W-1:0];
  assign rin_rise  = rin_flag & ~flag_prev_q;
  assign last_tick = frame_tick && (cnt_q == CNT_W'(THROW_FRAMES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      flag_prev_q <= 1'b0;
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      flag_q      <= 1'b0;
      anim_q      <= 1'b0;
      cnt_q       <= '0;
      opow_q      <= '0;
      tpow_q      <= '0;
    end else begin
      sync_q[0] <= {in_ready, in_throw_flag, in_power};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      flag_prev_q <= rin_flag;
      state_q     <= state_d;
      ready_q     <= ready_d;
      flag_q      <= flag_d;
      anim_q      <= anim_d;
      cnt_q       <= cnt_d;
      opow_q      <= opow_d;
      tpow_q      <= tpow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    flag_d  = flag_q;
    anim_d  = 1'b0;
    cnt_d   = cnt_q;
    opow_d  = opow_q;
    tpow_d  = tpow_q;

    if (state_q == IDLE && local_ready) ready_d = 1'b1;

    // Abort paths outrank every normal transition; throw_power survives for the display.
    if (game_over || (state_q != IDLE && !rin_ready)) begin
      state_d = IDLE;
      ready_d = 1'b0;
      flag_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ready_q && rin_ready) state_d = local_is_p1 ? LOCAL_TURN : REMOTE_TURN;
        end
        LOCAL_TURN: begin
          if (local_throw && local_power != '0) begin
            opow_d  = local_power;
            tpow_d  = local_power;
            state_d = LOCAL_ARM;
          end
        end
        LOCAL_ARM: begin
          flag_d  = 1'b1;
          anim_d  = 1'b1;
          cnt_d   = '0;
          state_d = LOCAL_FLIGHT;
        end
        LOCAL_FLIGHT: begin
          if (frame_tick) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (last_tick) begin
              flag_d  = 1'b0;
              state_d = REMOTE_TURN;
            end
          end
        end
        REMOTE_TURN: begin
          if (rin_rise) begin
            tpow_d  = rin_power;
            anim_d  = 1'b1;
            cnt_d   = '0;
            state_d = REMOTE_FLIGHT;
          end
        end
        REMOTE_FLIGHT: begin
          if (frame_tick) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (last_tick) state_d = LOCAL_TURN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign out_ready      = ready_q;
  assign out_throw_flag = flag_q;
  assign out_power      = opow_q;
  assign throw_power    = tpow_q;
  assign anim_start     = anim_q;
  assign my_turn        = (state_q == LOCAL_TURN);
  assign throw_local    = (state_q == LOCAL_FLIGHT);
  assign throw_active   = (state_q == LOCAL_FLIGHT) || (state_q == REMOTE_FLIGHT);

endmodule

// File: tb/tb_turn_ctrl.sv
// Bench for turn_ctrl: directed walk through a full game round plus randomized
// traffic, every cycle compared with a phase/countdown model of the turn rules.
module tb_turn_ctrl;

  localparam int PW = 5;
  localparam int SS = 2;
  localparam int TF = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          local_is_p1 = 1'b0, local_ready = 1'b0, local_throw = 1'b0;
  logic [PW-1:0] local_power = '0;
  logic          frame_tick = 1'b0, game_over = 1'b0;
  logic          in_ready = 1'b0, in_throw_flag = 1'b0;
  logic [PW-1:0] in_power = '0;
  logic          out_ready, out_throw_flag, my_turn, throw_active, throw_local, anim_start;
  logic [PW-1:0] out_power, throw_power;

  turn_ctrl #(.POWER_W(PW), .SYNC_STAGES(SS), .THROW_FRAMES(TF)) dut (
    .clk(clk), .rst_n(rst_n), .local_is_p1(local_is_p1), .local_ready(local_ready),
    .local_throw(local_throw), .local_power(local_power), .frame_tick(frame_tick),
    .game_over(game_over), .in_ready(in_ready), .in_throw_flag(in_throw_flag),
    .in_power(in_power), .out_ready(out_ready), .out_throw_flag(out_throw_flag),
    .out_power(out_power), .my_turn(my_turn), .throw_active(throw_active),
    .throw_local(throw_local), .throw_power(throw_power), .anim_start(anim_start)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: game phase plus frames-remaining countdown.
  localparam int M_IDLE = 0, M_MINE = 1, M_ARM = 2, M_MINE_AIR = 3, M_THEIRS = 4, M_THEIR_AIR = 5;
  int          m_phase, m_left;
  bit [PW+1:0] m_sync [SS];
  bit          m_prev, m_ready, m_flag, m_anim;
  bit [PW-1:0] m_opow, m_tpow;

  task automatic model_reset();
    m_phase = M_IDLE; m_left = 0; m_prev = 0; m_ready = 0; m_flag = 0; m_anim = 0;
    m_opow = '0; m_tpow = '0;
    for (int i = 0; i < SS; i++) m_sync[i] = '0;
  endtask

  task automatic model_update();
    bit rr, rf, rise, go;
    bit [PW-1:0] rp;
    rr = m_sync[SS-1][PW+1];
    rf = m_sync[SS-1][PW];
    rp = m_sync[SS-1][PW-1:0];
    rise = rf && !m_prev;
    m_prev = rf;
    for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = {in_ready, in_throw_flag, in_power};
    m_anim = 0;
    if (game_over || (m_phase != M_IDLE && !rr)) begin
      m_phase = M_IDLE; m_ready = 0; m_flag = 0; m_left = 0;
      return;
    end
    case (m_phase)
      M_IDLE: begin
        go = m_ready && rr;
        if (local_ready) m_ready = 1;
        if (go) m_phase = local_is_p1 ? M_MINE : M_THEIRS;
      end
      M_MINE: if (local_throw && local_power != 0) begin
        m_opow = local_power; m_tpow = local_power; m_phase = M_ARM;
      end
      M_ARM: begin
        m_flag = 1; m_anim = 1; m_left = TF; m_phase = M_MINE_AIR;
      end
      M_MINE_AIR, M_THEIR_AIR: if (frame_tick) begin
        m_left--;
        if (m_left == 0) begin
          m_flag = 0;
          m_phase = (m_phase == M_MINE_AIR) ? M_THEIRS : M_MINE;
        end
      end
      M_THEIRS: if (rise) begin
        m_tpow = rp; m_anim = 1; m_left = TF; m_phase = M_THEIR_AIR;
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("out_ready", out_ready, m_ready);
    chk("out_throw_flag", out_throw_flag, m_flag);
    chk("out_power", out_power, m_opow);
    chk("throw_power", throw_power, m_tpow);
    chk("anim_start", anim_start, m_anim);
    chk("my_turn", my_turn, m_phase == M_MINE);
    chk("throw_local", throw_local, m_phase == M_MINE_AIR);
    chk("throw_active", throw_active, m_phase == M_MINE_AIR || m_phase == M_THEIR_AIR);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_ready"}, out_ready, 0);
    chk({tag, "_out_flag"}, out_throw_flag, 0);
    chk({tag, "_out_power"}, out_power, 0);
    chk({tag, "_throw_power"}, throw_power, 0);
    chk({tag, "_anim"}, anim_start, 0);
    chk({tag, "_my_turn"}, my_turn, 0);
    chk({tag, "_active"}, throw_active, 0);
    chk({tag, "_local"}, throw_local, 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick_frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Start-up as player 1
    local_is_p1 = 1'b1; local_ready = 1'b1; in_ready = 1'b1;
    step();
    chk("startup_out_ready", out_ready, 1);
    for (int i = 0; i < SS + 1 && !my_turn; i++) step();
    chk("startup_my_turn", my_turn, 1);

    // Local throw with power 17
    local_throw = 1'b1; local_power = 5'd17; step();
    local_throw = 1'b0; local_power = 5'd0;
    chk("lthrow_power_T1", out_power, 17);
    chk("lthrow_flag_T1", out_throw_flag, 0);
    step();
    chk("lthrow_flag_T2", out_throw_flag, 1);
    chk("lthrow_anim_T2", anim_start, 1);
    for (int k = 0; k < TF; k++) begin
      chk("lflight_flag_held", out_throw_flag, 1);
      tick_frames(1);
    end
    chk("lflight_flag_end", out_throw_flag, 0);
    chk("lflight_inactive", throw_active, 0);

    // Local throw while remote has the turn is dropped
    local_throw = 1'b1; local_power = 5'd5; step();
    local_throw = 1'b0; local_power = 5'd0; step();
    chk("ignored_remote_power", out_power, 17);
    chk("ignored_remote_state", throw_active, 0);

    // Remote throw with power 9
    in_power = 5'd9; step(); step();
    in_throw_flag = 1'b1;
    for (int i = 0; i < SS + 3 && !anim_start; i++) step();
    chk("rthrow_anim", anim_start, 1);
    chk("rthrow_power", throw_power, 9);
    chk("rthrow_active", throw_active, 1);
    step();
    chk("rthrow_anim_width", anim_start, 0);
    tick_frames(TF);
    chk("rflight_back_to_me", my_turn, 1);

    // Zero-power throw is ignored
    local_throw = 1'b1; local_power = 5'd0; step();
    local_throw = 1'b0; step();
    chk("zero_power_turn", my_turn, 1);
    chk("zero_power_out", out_power, 17);

    // Peer loss mid local flight
    local_throw = 1'b1; local_power = 5'd22; step();
    local_throw = 1'b0; step(); step();
    in_ready = 1'b0;
    for (int i = 0; i < SS + 3 && throw_active; i++) step();
    chk("peerloss_inactive", throw_active, 0);
    chk("peerloss_flag", out_throw_flag, 0);
    chk("peerloss_ready", out_ready, 0);
    chk("peerloss_power_kept", throw_power, 22);
    in_ready = 1'b1;
    for (int i = 0; i < 10 && !my_turn; i++) step();
    chk("rejoin_my_turn", my_turn, 1);

    // game_over coincident with a throw
    local_throw = 1'b1; local_power = 5'd11; game_over = 1'b1; step();
    local_throw = 1'b0; game_over = 1'b0;
    chk("gameover_idle", my_turn, 0);
    chk("gameover_ready", out_ready, 0);
    chk("gameover_no_power", out_power, 22);
    step();
    chk("gameover_no_anim", anim_start, 0);

    // Rejoin as player 2 and reach remote flight, then async reset
    in_throw_flag = 1'b0; local_is_p1 = 1'b0;
    repeat (6) step();
    in_power = 5'd3; step(); step();
    in_throw_flag = 1'b1;
    for (int i = 0; i < SS + 3 && !throw_active; i++) step();
    chk("p2_remote_flight", throw_active, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_throw_flag = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      in_ready      = ($urandom_range(0, 199) != 0);
      game_over     = ($urandom_range(0, 299) == 0);
      local_ready   = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 99) == 0) local_is_p1 = $urandom_range(0, 1);
      local_throw   = ($urandom_range(0, 7) == 0);
      local_power   = ($urandom_range(0, 5) == 0) ? 5'd0 : PW'($urandom_range(1, 31));
      frame_tick    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) in_throw_flag = ~in_throw_flag;
      if (!in_throw_flag) in_power = PW'($urandom_range(0, 31));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
